// File: rtl/scope_pkg.sv
// Shared types and constants for the scope capture path.
package scope_pkg;

   localparam int DEFAULT_DEPTH = 640;
   localparam int DATA_W        = 10;
   localparam int ADDR_W        = 10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREFILL,
      ST_ARMED,
      ST_POST,
      ST_DONE
   } state_e;

   typedef enum logic [1:0] {
      MODE_NORMAL     = 2'b00,
      MODE_AUTO       = 2'b01,
      MODE_SINGLE     = 2'b10,
      MODE_NORMAL_ALT = 2'b11
   } mode_e;

endpackage

// File: rtl/trigger_detect.sv
// Combinational edge detector: compares the previous and current sample against a level.
module trigger_detect
   import scope_pkg::*;
(
   input  logic [DATA_W-1:0] i_prev,
   input  logic [DATA_W-1:0] i_sample,
   input  logic [DATA_W-1:0] i_level,
   input  logic              i_falling,
   output logic              o_trig
);

   logic rise;
   logic fall;

   always_comb begin
      rise   = (i_prev < i_level) && (i_sample >= i_level);
      fall   = (i_prev > i_level) && (i_sample <= i_level);
      o_trig = i_falling ? fall : rise;
   end

endmodule

// File: rtl/capture_controller.sv
// Oscilloscope capture sequencer: pre-trigger fill, armed trigger search, post-trigger fill,
// then holds the frame until the display acknowledges it.
module capture_controller
   import scope_pkg::*;
#(
   parameter int DEPTH        = DEFAULT_DEPTH,
   parameter int PRE          = 320,
   parameter int AUTO_TIMEOUT = 4096
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_sample_valid,
   input  logic [DATA_W-1:0] i_sample,
   input  logic [DATA_W-1:0] i_level,
   input  logic              i_falling,
   input  logic [1:0]        i_mode,
   input  logic              i_arm,
   input  logic              i_frame_ack,
   output logic              o_wr_en,
   output logic [ADDR_W-1:0] o_wr_addr,
   output logic [DATA_W-1:0] o_wr_data,
   output logic              o_frame_ready,
   output logic [ADDR_W-1:0] o_start_addr,
   output logic              o_auto_fired
);

   localparam int POST_LEN = DEPTH - PRE - 1;
   localparam int AUTO_W   = $clog2(AUTO_TIMEOUT) + 1;

   state_e              state_q,      state_d;
   mode_e               mode_q,       mode_d;
   logic [ADDR_W-1:0]   wptr_q,       wptr_d;
   logic [DATA_W-1:0]   prev_q,       prev_d;
   logic [ADDR_W-1:0]   cnt_q,        cnt_d;
   logic [AUTO_W-1:0]   auto_cnt_q,   auto_cnt_d;
   logic                wr_en_q,      wr_en_d;
   logic [ADDR_W-1:0]   wr_addr_q,    wr_addr_d;
   logic [DATA_W-1:0]   wr_data_q,    wr_data_d;
   logic [ADDR_W-1:0]   start_addr_q, start_addr_d;
   logic                auto_fired_q, auto_fired_d;

   logic                accept;
   logic                trig;
   logic                auto_hit;
   logic [ADDR_W-1:0]   wptr_inc;
   logic [ADDR_W-1:0]   frame_start;

   trigger_detect u_trigger_detect (
      .i_prev    (prev_q),
      .i_sample  (i_sample),
      .i_level   (i_level),
      .i_falling (i_falling),
      .o_trig    (trig)
   );

   // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned (no latch).
   always_comb begin
      state_d      = state_q;
      mode_d       = mode_q;
      wptr_d       = wptr_q;
      prev_d       = prev_q;
      cnt_d        = cnt_q;
      auto_cnt_d   = auto_cnt_q;
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      start_addr_d = start_addr_q;
      auto_fired_d = auto_fired_q;

      accept   = i_sample_valid &&
                 ((state_q == ST_PREFILL) || (state_q == ST_ARMED) || (state_q == ST_POST));
      wptr_inc = (wptr_q == ADDR_W'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
      auto_hit = (mode_q == MODE_AUTO) && (auto_cnt_q == AUTO_W'(AUTO_TIMEOUT - 1));

      // The frame starts PRE slots behind the trigger slot, wrapping around the buffer.
      if (wptr_q >= ADDR_W'(PRE)) frame_start = wptr_q - ADDR_W'(PRE);
      else                        frame_start = wptr_q + ADDR_W'(DEPTH - PRE);

      if (accept) begin
         wr_en_d   = 1'b1;
         wr_addr_d = wptr_q;
         wr_data_d = i_sample;
         wptr_d    = wptr_inc;
         prev_d    = i_sample;
      end

      case (state_q)
         ST_IDLE: begin
            if ((i_mode != MODE_SINGLE) || i_arm) begin
               state_d      = ST_PREFILL;
               mode_d       = mode_e'(i_mode);
               cnt_d        = '0;
               auto_fired_d = 1'b0;
            end
         end
         ST_PREFILL: begin
            if (accept) begin
               if (cnt_q == ADDR_W'(PRE - 1)) begin
                  state_d    = ST_ARMED;
                  cnt_d      = '0;
                  auto_cnt_d = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ST_ARMED: begin
            if (accept) begin
               if (mode_q == MODE_AUTO) auto_cnt_d = auto_cnt_q + 1'b1;
               if (trig || auto_hit) begin
                  start_addr_d = frame_start;
                  auto_fired_d = !trig;
                  cnt_d        = '0;
                  state_d      = (POST_LEN == 0) ? ST_DONE : ST_POST;
               end
            end
         end
         ST_POST: begin
            if (accept) begin
               if (cnt_q == ADDR_W'(POST_LEN - 1)) state_d = ST_DONE;
               else                                 cnt_d   = cnt_q + 1'b1;
            end
         end
         ST_DONE: begin
            if (i_frame_ack) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= ST_IDLE;
         mode_q       <= MODE_NORMAL;
         wptr_q       <= '0;
         prev_q       <= '0;
         cnt_q        <= '0;
         auto_cnt_q   <= '0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         start_addr_q <= '0;
         auto_fired_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         mode_q       <= mode_d;
         wptr_q       <= wptr_d;
         prev_q       <= prev_d;
         cnt_q        <= cnt_d;
         auto_cnt_q   <= auto_cnt_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         start_addr_q <= start_addr_d;
         auto_fired_q <= auto_fired_d;
      end
   end

   assign o_wr_en       = wr_en_q;
   assign o_wr_addr     = wr_addr_q;
   assign o_wr_data     = wr_data_q;
   assign o_frame_ready = (state_q == ST_DONE);
   assign o_start_addr  = start_addr_q;
   assign o_auto_fired  = auto_fired_q;

endmodule

// File: tb/tb_capture_controller.sv
// Directed bench for capture_controller: normal, falling-with-wrap, auto timeout and
// priority, single mode, and gapped capture aborted by reset.
module tb_capture_controller;

   logic       clk = 1'b0;
   logic       i_rst;
   logic       i_sample_valid;
   logic [9:0] i_sample;
   logic [9:0] i_level;
   logic       i_falling;
   logic [1:0] i_mode;
   logic       i_arm;
   logic       i_frame_ack;
   logic       o_wr_en;
   logic [9:0] o_wr_addr;
   logic [9:0] o_wr_data;
   logic       o_frame_ready;
   logic [9:0] o_start_addr;
   logic       o_auto_fired;

   int         checks = 0;
   int         errors = 0;
   int         wr_count = 0;
   int         base;
   logic [9:0] mem [0:639];

   capture_controller dut (
      .i_clk          (clk),
      .i_rst          (i_rst),
      .i_sample_valid (i_sample_valid),
      .i_sample       (i_sample),
      .i_level        (i_level),
      .i_falling      (i_falling),
      .i_mode         (i_mode),
      .i_arm          (i_arm),
      .i_frame_ack    (i_frame_ack),
      .o_wr_en        (o_wr_en),
      .o_wr_addr      (o_wr_addr),
      .o_wr_data      (o_wr_data),
      .o_frame_ready  (o_frame_ready),
      .o_start_addr   (o_start_addr),
      .o_auto_fired   (o_auto_fired)
   );

   always #5 clk = ~clk;

   // Write monitor: records every frame-buffer write mid-cycle.
   always @(negedge clk) begin
      if (o_wr_en === 1'b1) begin
         wr_count = wr_count + 1;
         if (o_wr_addr < 10'd640) mem[o_wr_addr] = o_wr_data;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input logic [9:0] v);
      i_sample_valid = 1'b1;
      i_sample       = v;
      step();
      i_sample_valid = 1'b0;
   endtask

   task automatic feed_gap(input logic [9:0] v);
      feed(v);
      step();
      step();
   endtask

   task automatic do_reset();
      i_rst          = 1'b1;
      i_sample_valid = 1'b0;
      i_arm          = 1'b0;
      i_frame_ack    = 1'b0;
      step();
      step();
      i_rst = 1'b0;
   endtask

   function automatic logic [9:0] ramp(input int k);
      return 10'((4 * k) % 1024);
   endfunction

   function automatic logic [9:0] square(input int k);
      if (k < 600) return 10'd800;
      return (((k - 600) / 50) % 2 == 0) ? 10'd800 : 10'd200;
   endfunction

   initial begin
      i_sample  = '0;
      i_level   = 10'd512;
      i_falling = 1'b0;
      i_mode    = 2'b00;

      // Reset state
      do_reset();
      check("rst_wr_en", o_wr_en, 0);
      check("rst_frame_ready", o_frame_ready, 0);
      check("rst_start_addr", o_start_addr, 0);
      check("rst_auto_fired", o_auto_fired, 0);

      // Normal rising ramp: trigger on value 512 at k=384, start 64, last write k=703 at addr 63
      step();
      step();
      base = wr_count;
      for (int k = 0; k < 384; k++) feed(ramp(k));
      check("ramp_pre_start", o_start_addr, 0);
      feed(ramp(384));
      check("ramp_trig_wr_en", o_wr_en, 1);
      check("ramp_trig_addr", o_wr_addr, 384);
      check("ramp_trig_data", o_wr_data, 512);
      check("ramp_start", o_start_addr, 64);
      check("ramp_auto", o_auto_fired, 0);
      for (int k = 385; k < 703; k++) feed(ramp(k));
      check("ramp_not_ready", o_frame_ready, 0);
      feed(ramp(703));
      check("ramp_ready", o_frame_ready, 1);
      for (int k = 0; k < 3; k++) feed(10'd1);
      step();
      check("ramp_writes", wr_count - base, 704);
      check("ramp_mem_trig", mem[384], 512);
      check("ramp_mem_last", mem[63], 764);
      check("ramp_mem_first", mem[64], 256);
      check("ramp_hold_ready", o_frame_ready, 1);
      i_frame_ack = 1'b1;
      step();
      i_frame_ack = 1'b0;
      check("ramp_ack_clear", o_frame_ready, 0);

      // Falling square wave with wrap: trigger at k=650 -> addr 10, start 330
      i_falling = 1'b1;
      do_reset();
      step();
      step();
      base = wr_count;
      for (int k = 0; k < 650; k++) feed(square(k));
      check("fall_pre_start", o_start_addr, 0);
      feed(square(650));
      check("fall_trig_addr", o_wr_addr, 10);
      check("fall_trig_data", o_wr_data, 200);
      check("fall_start", o_start_addr, 330);
      for (int k = 651; k < 970; k++) feed(square(k));
      check("fall_ready", o_frame_ready, 1);
      step();
      step();
      check("fall_writes", wr_count - base, 970);
      check("fall_mem_trig", mem[10], 200);
      check("fall_mem_last", mem[329], 200);
      check("fall_mem_first", mem[330], 800);

      // Auto timeout: 4096th ARMED sample is k=4415 -> addr 575, start 255; mode change must be ignored
      i_falling = 1'b0;
      i_mode    = 2'b01;
      do_reset();
      step();
      i_mode = 2'b00;
      step();
      base = wr_count;
      for (int k = 0; k < 4415; k++) feed(10'd100);
      check("auto_pre_fired", o_auto_fired, 0);
      check("auto_pre_start", o_start_addr, 0);
      feed(10'd100);
      check("auto_trig_addr", o_wr_addr, 575);
      check("auto_start", o_start_addr, 255);
      check("auto_fired", o_auto_fired, 1);
      for (int k = 0; k < 319; k++) feed(10'd100);
      check("auto_ready", o_frame_ready, 1);
      check("auto_fired_hold", o_auto_fired, 1);
      step();
      check("auto_writes", wr_count - base, 4735);
      i_frame_ack = 1'b1;
      step();
      i_frame_ack = 1'b0;
      check("auto_ack_clear", o_frame_ready, 0);
      check("auto_fired_idle", o_auto_fired, 1);
      step();
      check("auto_fired_exit", o_auto_fired, 0);

      // Genuine trigger on the timeout sample wins
      i_mode = 2'b01;
      do_reset();
      step();
      step();
      for (int k = 0; k < 4415; k++) feed(10'd100);
      feed(10'd600);
      check("prio_start", o_start_addr, 255);
      check("prio_fired", o_auto_fired, 0);

      // Single mode: nothing without arm, one frame after arm, then parked in IDLE
      i_mode = 2'b10;
      do_reset();
      base = wr_count;
      for (int k = 0; k < 20; k++) feed(10'd700);
      step();
      check("single_no_arm_writes", wr_count - base, 0);
      check("single_no_arm_ready", o_frame_ready, 0);
      i_arm = 1'b1;
      step();
      i_arm = 1'b0;
      step();
      for (int k = 0; k < 704; k++) feed(ramp(k));
      check("single_ready", o_frame_ready, 1);
      check("single_start", o_start_addr, 64);
      i_frame_ack = 1'b1;
      step();
      i_frame_ack = 1'b0;
      for (int k = 0; k < 20; k++) feed(10'd700);
      step();
      check("single_writes", wr_count - base, 704);
      check("single_idle_ready", o_frame_ready, 0);

      // Gapped valid, reset on the cycle after POST sample 100 (k=484)
      i_mode = 2'b00;
      do_reset();
      step();
      step();
      base = wr_count;
      for (int k = 0; k < 385; k++) feed_gap(ramp(k));
      check("gap_start", o_start_addr, 64);
      for (int k = 385; k < 484; k++) feed_gap(ramp(k));
      feed(ramp(484));
      check("gap_last_data", o_wr_data, 912);
      i_rst          = 1'b1;
      i_mode         = 2'b10;
      i_sample_valid = 1'b1;
      i_sample       = ramp(485);
      step();
      check("gap_rst_wr_en", o_wr_en, 0);
      check("gap_rst_wr_addr", o_wr_addr, 0);
      check("gap_rst_wr_data", o_wr_data, 0);
      check("gap_rst_start", o_start_addr, 0);
      check("gap_rst_ready", o_frame_ready, 0);
      check("gap_rst_fired", o_auto_fired, 0);
      i_rst          = 1'b0;
      i_sample_valid = 1'b0;
      for (int k = 0; k < 6; k++) feed_gap(ramp(k));
      check("gap_writes", wr_count - base, 485);
      check("gap_idle_ready", o_frame_ready, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
